// File: rtl/bipartite_xbar_sched_pkg.sv
// Shared types and width helpers for the bipartite crossbar valve scheduler.
// Optional flush stage is enabled by defining BIPARTITE_XBAR_FLUSH_EN.
package bipartite_xbar_pkg;

  // Scheduler states; FLUSH exists only when the flush stage is built in.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPEN_OUT = 3'd1,
    ST_FLOW     = 3'd2,
    ST_DRAIN    = 3'd3
`ifdef BIPARTITE_XBAR_FLUSH_EN
    ,ST_FLUSH   = 3'd4
`endif
  } state_e;

  // Width of an index able to address n channels (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Shared down-counter width: must hold dur-1, SETTLE-1 and FLUSH_CYCLES-1.
  function automatic int cnt_w(input int dur_w, input int settle, input int flush);
    int w;
    w = dur_w;
    if ($clog2(settle + 1) > w) w = $clog2(settle + 1);
    if ($clog2(flush + 1) > w) w = $clog2(flush + 1);
    return w;
  endfunction

endpackage

// File: rtl/bipartite_xbar_sched_if.sv
// Request/valve bundle between the assay controller (master) and the
// crossbar scheduler (slave). flush_valve exists with BIPARTITE_XBAR_FLUSH_EN.
interface bipartite_xbar_sched_if #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 16,
  parameter int DUR_W = 16
);
  import bipartite_xbar_pkg::*;

  localparam int SRC_W = idx_w(N_IN);
  localparam int DST_W = idx_w(N_OUT);

  logic             req_valid;
  logic             req_ready;
  logic [SRC_W-1:0] req_src;
  logic [DST_W-1:0] req_dst;
  logic [DUR_W-1:0] req_dur;
  logic             abort;
  logic [N_IN-1:0]  in_valve;
  logic [N_OUT-1:0] out_valve;
  logic             busy;
  logic             done;
  logic             err;
`ifdef BIPARTITE_XBAR_FLUSH_EN
  logic             flush_valve;
`endif

  modport master (
`ifdef BIPARTITE_XBAR_FLUSH_EN
    input  flush_valve,
`endif
    output req_valid, req_src, req_dst, req_dur, abort,
    input  req_ready, in_valve, out_valve, busy, done, err
  );

  modport slave (
`ifdef BIPARTITE_XBAR_FLUSH_EN
    output flush_valve,
`endif
    input  req_valid, req_src, req_dst, req_dur, abort,
    output req_ready, in_valve, out_valve, busy, done, err
  );

endinterface

// File: rtl/bipartite_xbar_sched_countdown.sv
// Loadable down-counter shared by all timed scheduler phases. It holds at
// zero, so a phase ends on the edge where zero_o is seen.
module xbar_countdown #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/bipartite_xbar_sched.sv
// Crossbar valve scheduler: one transfer at a time, outlet opened before and
// held after the inlet, so at most one inlet and one outlet are ever open.
// Define BIPARTITE_XBAR_FLUSH_EN to add a flush stage after the drain.
module bipartite_xbar_sched
  import bipartite_xbar_pkg::*;
#(
  parameter int N_IN         = 16,
  parameter int N_OUT        = 16,
  parameter int DUR_W        = 16,
  parameter int SETTLE       = 4,
  parameter int FLUSH_CYCLES = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  bipartite_xbar_sched_if.slave bus
);

  localparam int SRC_W = idx_w(N_IN);
  localparam int DST_W = idx_w(N_OUT);
  localparam int CNT_W = cnt_w(DUR_W, SETTLE, FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE - 1);
`ifdef BIPARTITE_XBAR_FLUSH_EN
  localparam logic [CNT_W-1:0] FLUSH_VAL  = CNT_W'(FLUSH_CYCLES - 1);
`endif

  state_e           state_q;
  logic [SRC_W-1:0] src_q;
  logic [DST_W-1:0] dst_q;
  logic [DUR_W-1:0] dur_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [N_IN-1:0]  in_valve_q;
  logic [N_OUT-1:0] out_valve_q;
`ifdef BIPARTITE_XBAR_FLUSH_EN
  logic             flush_q;
`endif

  logic             accept_s;
  logic             req_ok_s;
  logic             start_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_zero_s;

  function automatic logic [N_IN-1:0] in_onehot(input logic [SRC_W-1:0] idx);
    logic [N_IN-1:0] v;
    v      = {N_IN{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [N_OUT-1:0] out_onehot(input logic [DST_W-1:0] idx);
    logic [N_OUT-1:0] v;
    v      = {N_OUT{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // A handshake only happens in IDLE because ready is high only there.
  assign accept_s = (state_q == ST_IDLE) && bus.req_valid && ready_q;
  assign req_ok_s = (32'(bus.req_src) < N_IN) && (32'(bus.req_dst) < N_OUT) &&
                    (bus.req_dur != {DUR_W{1'b0}});
  assign start_s  = accept_s && req_ok_s;

  xbar_countdown #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (cnt_load_s),
    .value_i (cnt_val_s),
    .zero_o  (cnt_zero_s)
  );

  // Reload the shared counter on every phase entry (length minus one).
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_val_s  = SETTLE_VAL;
    case (state_q)
      ST_IDLE: begin
        cnt_load_s = start_s;
      end
      ST_OPEN_OUT: begin
        if (bus.abort) begin
          cnt_load_s = 1'b1;
        end else if (cnt_zero_s) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(dur_q - {{(DUR_W-1){1'b0}}, 1'b1});
        end else begin
          cnt_load_s = 1'b0;
        end
      end
      ST_FLOW: begin
        cnt_load_s = bus.abort | cnt_zero_s;
      end
      ST_DRAIN: begin
`ifdef BIPARTITE_XBAR_FLUSH_EN
        cnt_load_s = cnt_zero_s;
        cnt_val_s  = FLUSH_VAL;
`else
        cnt_load_s = 1'b0;
`endif
      end
      default: begin
        cnt_load_s = 1'b0;
      end
    endcase
  end

  // Transfer sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      src_q       <= {SRC_W{1'b0}};
      dst_q       <= {DST_W{1'b0}};
      dur_q       <= {DUR_W{1'b0}};
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      in_valve_q  <= {N_IN{1'b0}};
      out_valve_q <= {N_OUT{1'b0}};
`ifdef BIPARTITE_XBAR_FLUSH_EN
      flush_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= ~start_s;
          if (start_s) begin
            state_q     <= ST_OPEN_OUT;
            src_q       <= bus.req_src;
            dst_q       <= bus.req_dst;
            dur_q       <= bus.req_dur;
            busy_q      <= 1'b1;
            out_valve_q <= out_onehot(bus.req_dst);
          end else if (accept_s) begin
            err_q <= 1'b1;
          end
        end
        ST_OPEN_OUT: begin
          if (bus.abort) begin
            state_q <= ST_DRAIN;
          end else if (cnt_zero_s) begin
            state_q    <= ST_FLOW;
            in_valve_q <= in_onehot(src_q);
          end
        end
        ST_FLOW: begin
          if (bus.abort || cnt_zero_s) begin
            state_q    <= ST_DRAIN;
            in_valve_q <= {N_IN{1'b0}};
          end
        end
        ST_DRAIN: begin
          if (cnt_zero_s) begin
`ifdef BIPARTITE_XBAR_FLUSH_EN
            state_q <= ST_FLUSH;
            flush_q <= 1'b1;
`else
            state_q     <= ST_IDLE;
            out_valve_q <= {N_OUT{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            ready_q     <= 1'b1;
`endif
          end
        end
`ifdef BIPARTITE_XBAR_FLUSH_EN
        ST_FLUSH: begin
          if (cnt_zero_s) begin
            state_q     <= ST_IDLE;
            flush_q     <= 1'b0;
            out_valve_q <= {N_OUT{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            ready_q     <= 1'b1;
          end
        end
`endif
        default: begin
          state_q     <= ST_IDLE;
          in_valve_q  <= {N_IN{1'b0}};
          out_valve_q <= {N_OUT{1'b0}};
          busy_q      <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.in_valve    = in_valve_q;
  assign bus.out_valve   = out_valve_q;
`ifdef BIPARTITE_XBAR_FLUSH_EN
  assign bus.flush_valve = flush_q;
`endif

endmodule

// File: tb/tb_bipartite_xbar_sched.sv
// Self-checking bench for bipartite_xbar_sched: directed test-plan scenarios
// plus random transfers, all checked every cycle against a timeline model.
module tb_bipartite_xbar_sched;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int S  = 4;
  localparam int IW = $clog2(N);
`ifdef BIPARTITE_XBAR_FLUSH_EN
  localparam int F  = 8;
`else
  localparam int F  = 0;
`endif

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  bipartite_xbar_sched_if #(.N_IN(N), .N_OUT(N), .DUR_W(DW)) bus ();

  bipartite_xbar_sched #(
    .N_IN(N), .N_OUT(N), .DUR_W(DW), .SETTLE(S), .FLUSH_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: one transfer described by its key cycle numbers.
  bit m_started = 1'b0;
  bit m_prev_rst = 1'b0;
  bit m_act = 1'b0;
  int m_t = 0, m_src = 0, m_dst = 0, m_flow_end = 0, m_drain_end = 0;
  int m_err_cyc = -10;

  initial begin
    forever begin
      int c;
      bit e_busy, e_done, e_err, e_ready, e_flow;
      logic [31:0] e_in, e_out;
      @(negedge clk);
      c       = cyc;
      e_busy  = m_act && (c >= m_t + 1) && (c <= m_drain_end);
      e_flow  = m_act && (c >= m_t + S + 1) && (c <= m_flow_end);
      e_done  = m_act && (c == m_drain_end + 1);
      e_err   = (c == m_err_cyc);
      e_ready = !m_prev_rst && !e_busy;
      e_out   = e_busy ? (32'd1 << m_dst) : 32'd0;
      e_in    = e_flow ? (32'd1 << m_src) : 32'd0;
      if (m_started) begin
        check("in_valve", 32'(bus.in_valve), e_in);
        check("out_valve", 32'(bus.out_valve), e_out);
        check("busy", 32'(bus.busy), 32'(e_busy));
        check("done", 32'(bus.done), 32'(e_done));
        check("err", 32'(bus.err), 32'(e_err));
        check("req_ready", 32'(bus.req_ready), 32'(e_ready));
        check("in_needs_out", 32'((bus.in_valve == '0) || (bus.out_valve != '0)), 32'd1);
`ifdef BIPARTITE_XBAR_FLUSH_EN
        check("flush_valve", 32'(bus.flush_valve),
              32'(m_act && (c > m_drain_end - F) && (c <= m_drain_end)));
`endif
      end
      if (rst_n !== 1'b1) begin
        m_act = 1'b0; m_err_cyc = -10; m_prev_rst = 1'b1; m_started = 1'b1;
      end else begin
        m_prev_rst = 1'b0;
        if (m_act && bus.abort && (c >= m_t + 1) && (c <= m_flow_end)) begin
          m_flow_end  = c;
          m_drain_end = c + S + F;
        end
        if (e_ready && bus.req_valid) begin
          if (bus.req_dur != 0 && int'(bus.req_src) < N && int'(bus.req_dst) < N) begin
            m_act = 1'b1; m_t = c;
            m_src = int'(bus.req_src); m_dst = int'(bus.req_dst);
            m_flow_end  = c + S + int'(bus.req_dur);
            m_drain_end = c + 2 * S + int'(bus.req_dur) + F;
          end else begin
            m_err_cyc = c + 1;
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input int s, input int d, input int du, input bit hold, output int tacc);
    bus.req_src = IW'(s); bus.req_dst = IW'(d); bus.req_dur = DW'(du);
    bus.req_valid = 1'b1;
    tacc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin tacc = cyc; break; end
    end
    if (tacc < 0) check("accept_timeout", 32'd0, 32'd1);
    sync();
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int dc);
    dc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin dc = cyc; break; end
    end
    if (dc < 0) check("done_timeout", 32'd0, 32'd1);
    sync();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    sync();
  endtask

  task automatic abort_at(input int target);
    while (cyc < target) sync();
    bus.abort = 1'b1;
    sync();
    bus.abort = 1'b0;
  endtask

  initial begin
    int t, t2, dc, du, k;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_src = '0; bus.req_dst = '0; bus.req_dur = '0;
    bus.abort = 1'b0;
    repeat (3) sync();
    rst_n = 1'b1;
    sync();

    // Basic transfer src=3 dst=7 dur=10.
    send(3, 7, 10, 1'b0, t);
    wait_done(200, dc);
    check("lat_basic", 32'(dc - t), 32'(19 + F));

    // Rejected request (dur=0): err pulse only.
    send(5, 2, 0, 1'b0, t);
    @(negedge clk);
    check("rej_err", 32'(bus.err), 32'd1);
    check("rej_ready", 32'(bus.req_ready), 32'd1);
    check("rej_valve", 32'(bus.out_valve), 32'd0);
    sync();

    // Abort in the third FLOW cycle.
    send(3, 7, 10, 1'b0, t);
    abort_at(t + 7);
    wait_done(200, dc);
    check("lat_abort", 32'(dc - t), 32'(12 + F));

    // Back-to-back with req_valid held.
    send(3, 7, 10, 1'b1, t);
    send(0, 15, 1, 1'b0, t2);
    check("b2b_accept", 32'(t2 - t), 32'(19 + F));
    wait_done(200, dc);
    check("lat_b2b", 32'(dc - t2), 32'(2 * S + 1 + 1 + F));

    // Reset sampled mid-FLOW.
    send(1, 2, 20, 1'b0, t);
    while (cyc < t + 8) sync();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in", 32'(bus.in_valve), 32'd0);
    check("rst_out", 32'(bus.out_valve), 32'd0);
    check("rst_ready_low", 32'(bus.req_ready), 32'd0);
    sync();
    @(negedge clk);
    check("rst_ready_high", 32'(bus.req_ready), 32'd1);
    sync();

    // Maximum duration completes without counter wrap.
    send(2, 4, 65535, 1'b0, t);
    wait_done(70000, dc);
    check("lat_max", 32'(dc - t), 32'(2 * S + 65535 + 1 + F));

    // Random transfers with random aborts and back-to-back requests.
    for (int i = 0; i < 40; i++) begin
      du = int'($urandom_range(0, 12));
      send(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)), du,
           1'b0, t);
      if ($urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(1, 2 * S + du + 2));
        abort_at(t + k);
      end
      if ($urandom_range(0, 1) == 0) wait_idle();
      repeat ($urandom_range(0, 2)) sync();
    end
    wait_idle();
    repeat (3) sync();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bipartite_xbar_sched.md
Name: bipartite_xbar_sched

Overview:
- Parametrised N_IN x N_OUT crossbar valve scheduler for complete-bipartite microfluidic routing fabrics.
- Accepts one transfer request (src, dst, duration) at a time over a valid/ready handshake.
- Sequences the valves as: open outlet, settle, open inlet for the duration, close inlet, drain, done.
- Guarantees that at most one inlet and one outlet are ever open. Sits between the assay controller and the valve driver bank.

Parameters:
- N_IN, 16, number of inlet channels (>=2)
- N_OUT, 16, number of outlet channels (>=2)
- DUR_W, 16, width of the flow-duration field in cycles
- SETTLE, 4, outlet-only cycles before inlet open and after inlet close (>=1)
- FLUSH_CYCLES, 8, flush length in cycles; used only with the optional feature

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE, low while rst_n=0
- req_src  in  $clog2(N_IN)  inlet index
- req_dst  in  $clog2(N_OUT)  outlet index
- req_dur  in  DUR_W  inlet-open cycles
- abort  in  1  terminate the current transfer early
- in_valve  out  N_IN  one-hot-or-zero inlet valve enables
- out_valve  out  N_OUT  one-hot-or-zero outlet valve enables
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on transfer completion
- err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset:
  - Sampled on a clk edge with rst_n=0. Applies from any state, including mid-transfer.
  - Next cycle: all outputs are 0, state is IDLE, request registers are cleared.
  - req_ready rises in the first cycle after rst_n returns high.
- States: IDLE, OPEN_OUT, FLOW, DRAIN (plus FLUSH with the optional feature). A single down-counter of max(DUR_W, $clog2(SETTLE+1)) bits is reused across states.
- Accept: a request is accepted when req_valid & req_ready at edge t; src/dst/dur are latched. Reject the request if src>=N_IN, dst>=N_OUT, or dur==0:
  - err=1 in cycle t+1 only
  - state stays IDLE, no valve moves, req_ready stays high
- Valid request timeline:
  - OPEN_OUT, cycles t+1..t+SETTLE: out_valve[dst]=1.
  - FLOW, cycles t+SETTLE+1..t+SETTLE+dur: in_valve[src]=1 and out_valve[dst]=1.
  - DRAIN, next SETTLE cycles: out_valve[dst] only.
  - Then IDLE: valves 0, done=1 for exactly one cycle (t+2*SETTLE+dur+1 for a non-aborted transfer), req_ready=1 in that same cycle.
- Abort:
  - Sampled in OPEN_OUT or FLOW. The next cycle enters DRAIN with in_valve=0, runs the full SETTLE drain, then pulses done.
  - Ignored in IDLE and DRAIN.
  - If abort coincides with the last FLOW cycle, the normal timeline applies.
- Invariants:
  - popcount(in_valve)<=1 and popcount(out_valve)<=1.
  - in_valve!=0 implies out_valve!=0.
  - Valves change only on clk edges and are registered outputs.
- Counter: req_dur=2^DUR_W-1 must complete without wrap.
- Back-to-back: a request held valid is accepted in the done cycle. Its outlet opens the following cycle, so there are no overlapping valves.

Optional Feature:
- Macro: BIPARTITE_XBAR_FLUSH_EN.
- Defined: adds port flush_valve (out, 1) and a FLUSH state after DRAIN.
  - flush_valve=1 and out_valve[dst]=1 for FLUSH_CYCLES cycles, then IDLE/done.
  - done is delayed by FLUSH_CYCLES.
  - Aborted transfers also flush.
  - flush_valve resets to 0.
- Undefined: no port, no state; DRAIN goes directly to IDLE.

Decomposition:
- Package bipartite_xbar_pkg:
  - state enum typedef
  - localparam helpers for index widths ($clog2 of N_IN/N_OUT)
- Sub-module xbar_countdown: loadable down-counter with load, value, and zero flag. Instantiated once and used for SETTLE, dur and FLUSH_CYCLES.
- One-hot valve decode stays in the top level.

Test Plan:
- Defaults, src=3, dst=7, dur=10, accepted at t:
  - out_valve=16'h0080 over t+1..t+18
  - in_valve=16'h0008 over t+5..t+14
  - done at t+19
  - req_ready low over t+1..t+18
- src=16 (invalid), then dur=0 → err pulse at t+1, valves stay 0, req_ready stays 1, no done.
- Abort asserted in the 3rd FLOW cycle (t+7) → in_valve=0 from t+8, out_valve held t+8..t+11, done at t+12.
- req_valid held with a second request (src=0, dst=15, dur=1) → second accepted in the done cycle. out_valve=16'h8000 starts the next cycle and never overlaps 16'h0080.
- rst_n=0 sampled mid-FLOW → next cycle all valves 0, busy=0, done=0. req_ready=1 the first cycle after rst_n rises.
- With BIPARTITE_XBAR_FLUSH_EN, repeat the first test → flush_valve high over t+19..t+26, out_valve held to t+26, done at t+27.
